// File: rtl/typeracer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : typeracer_pkg
// Description : Constants and state encoding shared by the score statistics
//               block and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package typeracer_pkg;

    localparam int WPM_MAX = 999;
    localparam int ACC_MAX = 100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DIV     = 2'd2,
        ST_PUBLISH = 2'd3
    } stats_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring divider producing one quotient bit per clock. The
//               first step runs on the start cycle straight from the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DIVIDEND_W = 13,
    parameter int DIVISOR_W  = 4,
    parameter int QUOTIENT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [QUOTIENT_W-1:0] quotient
);

    localparam int c_CNT_W = $clog2(DIVIDEND_W + 1);

    logic                  r_active;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;

    logic [DIVIDEND_W-1:0] w_quo_in;
    logic [DIVISOR_W-1:0]  w_rem_in;
    logic [DIVISOR_W-1:0]  w_dvs;
    logic [c_CNT_W-1:0]    w_cnt;
    logic [DIVISOR_W:0]    w_shift;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_rem_next;

    always_comb begin
        w_quo_in = start ? dividend : r_quo;
        w_rem_in = start ? '0 : r_rem;
        w_dvs    = start ? divisor : r_divisor;
        w_cnt    = start ? '0 : r_cnt;
        w_shift  = {w_rem_in, w_quo_in[DIVIDEND_W-1]};
        w_ge     = (w_shift >= {1'b0, w_dvs});
        // The restored remainder is always below the divisor, so the low bits suffice.
        w_rem_next = w_ge ? (w_shift[DIVISOR_W-1:0] - w_dvs) : w_shift[DIVISOR_W-1:0];
    end

    assign done     = (start || r_active) && (w_cnt == c_CNT_W'(DIVIDEND_W - 1));
    assign quotient = r_quo[QUOTIENT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (abort) begin
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (start || r_active) begin
            r_active  <= !done;
            r_cnt     <= w_cnt + c_CNT_W'(1);
            r_quo     <= {w_quo_in[DIVIDEND_W-2:0], w_ge};
            r_rem     <= w_rem_next;
            r_divisor <= w_dvs;
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_stats.sv
`default_nettype none
// ============================================================================
// Module      : score_stats
// Description : All-time bests and sliding-window averages of WPM/accuracy
//               over the last DEPTH games, for the menu screen.
// Revision    : 1.0 - initial release
// ============================================================================
module score_stats
    import typeracer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     result_valid,
    input  logic [W-1:0]             wpm_in,
    input  logic [W-1:0]             acc_in,
    output logic [W-1:0]             wpm_best,
    output logic [W-1:0]             acc_best,
    output logic [W-1:0]             wpm_average,
    output logic [W-1:0]             acc_average,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = W + c_PTR_W;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    stats_state_t r_state;
    stats_state_t w_state_next;

    logic [W-1:0]       r_wpm_buf [DEPTH];
    logic [W-1:0]       r_acc_buf [DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_SUM_W-1:0] r_wpm_sum;
    logic [c_SUM_W-1:0] r_acc_sum;
    logic [W-1:0]       r_new_wpm;
    logic [W-1:0]       r_new_acc;
    logic               r_pend_valid;
    logic [W-1:0]       r_pend_wpm;
    logic [W-1:0]       r_pend_acc;
    logic               r_div_first;

    logic [W-1:0]       w_wpm_clamp;
    logic [W-1:0]       w_acc_clamp;
    logic               w_full;
    logic [W-1:0]       w_evict_wpm;
    logic [W-1:0]       w_evict_acc;
    logic               w_div_start;
    logic               w_wpm_done;
    logic               w_acc_done;
    logic               w_div_done;
    logic [W-1:0]       w_wpm_quo;
    logic [W-1:0]       w_acc_quo;

    assign w_wpm_clamp = (wpm_in > W'(WPM_MAX)) ? W'(WPM_MAX) : wpm_in;
    assign w_acc_clamp = (acc_in > W'(ACC_MAX)) ? W'(ACC_MAX) : acc_in;
    assign w_full      = (count == c_CNT_FULL);
    // Slots are only read for eviction once every one of them has been written.
    assign w_evict_wpm = w_full ? r_wpm_buf[r_ptr] : '0;
    assign w_evict_acc = w_full ? r_acc_buf[r_ptr] : '0;
    assign w_div_start = (r_state == ST_DIV) && r_div_first;
    assign w_div_done  = w_wpm_done && w_acc_done;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (r_pend_valid || result_valid) w_state_next = ST_ACCUM;
            ST_ACCUM:   w_state_next = ST_DIV;
            ST_DIV:     if (w_div_done) w_state_next = ST_PUBLISH;
            ST_PUBLISH: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
        if (clear) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            r_ptr        <= '0;
            r_wpm_sum    <= '0;
            r_acc_sum    <= '0;
            r_new_wpm    <= '0;
            r_new_acc    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_wpm   <= '0;
            r_pend_acc   <= '0;
            r_div_first  <= 1'b0;
            wpm_best     <= '0;
            acc_best     <= '0;
            wpm_average  <= '0;
            acc_average  <= '0;
            count        <= '0;
        end else begin
            r_div_first <= (r_state == ST_ACCUM);

            // A pulse that cannot start right away lands in the pending slot, newest wins.
            if (result_valid && ((r_state != ST_IDLE) || r_pend_valid)) begin
                r_pend_valid <= 1'b1;
                r_pend_wpm   <= w_wpm_clamp;
                r_pend_acc   <= w_acc_clamp;
            end else if ((r_state == ST_IDLE) && r_pend_valid) begin
                r_pend_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend_valid) begin
                        r_new_wpm <= r_pend_wpm;
                        r_new_acc <= r_pend_acc;
                    end else if (result_valid) begin
                        r_new_wpm <= w_wpm_clamp;
                        r_new_acc <= w_acc_clamp;
                    end
                end
                ST_ACCUM: begin
                    r_wpm_sum <= r_wpm_sum - c_SUM_W'(w_evict_wpm) + c_SUM_W'(r_new_wpm);
                    r_acc_sum <= r_acc_sum - c_SUM_W'(w_evict_acc) + c_SUM_W'(r_new_acc);
                    r_ptr     <= r_ptr + c_PTR_W'(1);
                    if (!w_full)              count    <= count + c_CNT_W'(1);
                    if (r_new_wpm > wpm_best) wpm_best <= r_new_wpm;
                    if (r_new_acc > acc_best) acc_best <= r_new_acc;
                end
                ST_PUBLISH: begin
                    wpm_average <= w_wpm_quo;
                    acc_average <= w_acc_quo;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_ACCUM) begin
            r_wpm_buf[r_ptr] <= r_new_wpm;
            r_acc_buf[r_ptr] <= r_new_acc;
        end
    end

    seq_divider #(
        .DIVIDEND_W (c_SUM_W),
        .DIVISOR_W  (c_CNT_W),
        .QUOTIENT_W (W)
    ) u_wpm_div (
        .clk      (clk),
        .rst      (rst),
        .abort    (clear),
        .start    (w_div_start),
        .dividend (r_wpm_sum),
        .divisor  (count),
        .done     (w_wpm_done),
        .quotient (w_wpm_quo)
    );

    seq_divider #(
        .DIVIDEND_W (c_SUM_W),
        .DIVISOR_W  (c_CNT_W),
        .QUOTIENT_W (W)
    ) u_acc_div (
        .clk      (clk),
        .rst      (rst),
        .abort    (clear),
        .start    (w_div_start),
        .dividend (r_acc_sum),
        .divisor  (count),
        .done     (w_acc_done),
        .quotient (w_acc_quo)
    );

endmodule
`default_nettype wire

// File: tb/tb_score_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_stats
// Description : Directed self-checking bench for score_stats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_stats;

    localparam int DEPTH = 8;
    localparam int W     = 10;
    localparam int LAT   = 2 + W + $clog2(DEPTH);

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         result_valid;
    logic [W-1:0] wpm_in;
    logic [W-1:0] acc_in;
    logic [W-1:0] wpm_best;
    logic [W-1:0] acc_best;
    logic [W-1:0] wpm_average;
    logic [W-1:0] acc_average;
    logic [3:0]   count;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_stats #(.DEPTH(DEPTH), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .result_valid (result_valid),
        .wpm_in       (wpm_in),
        .acc_in       (acc_in),
        .wpm_best     (wpm_best),
        .acc_best     (acc_best),
        .wpm_average  (wpm_average),
        .acc_average  (acc_average),
        .count        (count),
        .busy         (busy)
    );

    typedef struct {
        bit clr;
        int wpm;
        int acc;
        int best_w;
        int best_a;
        int avg_w;
        int avg_a;
        int cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wpm_best"}, 32'(wpm_best), 0);
        check({tag, "_acc_best"}, 32'(acc_best), 0);
        check({tag, "_wpm_avg"},  32'(wpm_average), 0);
        check({tag, "_acc_avg"},  32'(acc_average), 0);
        check({tag, "_count"},    32'(count), 0);
        check({tag, "_busy"},     32'(busy), 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // One-cycle pulse; returns just after the sampling edge E0.
    task automatic pulse(input int w, input int a);
        @(negedge clk);
        wpm_in       = W'(w);
        acc_in       = W'(a);
        result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
    endtask

    // Counts edges until busy drops, bounded.
    task automatic wait_idle(input string tag, output int edges);
        edges = 0;
        while (busy && edges < 60) begin
            @(posedge clk);
            #1 edges++;
        end
        if (busy) begin
            failures++;
            $display("FAIL %s_timeout: busy still 1 after %0d edges, required 0", tag, edges);
        end
    endtask

    task automatic run_game(input vec_t v, input string tag);
        int edges;
        if (v.clr) do_clear();
        pulse(v.wpm, v.acc);
        check({tag, "_busy_e0"}, 32'(busy), 1);
        @(posedge clk);
        #1;
        check({tag, "_wpm_best"}, 32'(wpm_best), v.best_w);
        check({tag, "_acc_best"}, 32'(acc_best), v.best_a);
        check({tag, "_count"},    32'(count),    v.cnt);
        wait_idle(tag, edges);
        check({tag, "_latency"}, 32'(edges + 1), LAT);
        check({tag, "_wpm_avg"}, 32'(wpm_average), v.avg_w);
        check({tag, "_acc_avg"}, 32'(acc_average), v.avg_a);
    endtask

    vec_t vecs[7];

    initial begin
        int edges;
        rst          = 1'b1;
        clear        = 1'b0;
        result_valid = 1'b0;
        wpm_in       = '0;
        acc_in       = '0;

        vecs[0] = '{1'b1,   50,   90,  50,  90,  50,  90, 1};
        vecs[1] = '{1'b1,   40,   80,  40,  80,  40,  80, 1};
        vecs[2] = '{1'b0,   60,  100,  60, 100,  50,  90, 2};
        vecs[3] = '{1'b0,   51,   95,  60, 100,  50,  91, 3};
        vecs[4] = '{1'b1, 1023, 1023, 999, 100, 999, 100, 1};
        vecs[5] = '{1'b0,   20,   50, 999, 100, 509,  75, 2};
        vecs[6] = '{1'b0,  999,    0, 999, 100, 672,  50, 3};

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_game(vecs[i], $sformatf("vec%0d", i));

        // Window wrap: ten..ninety, the ninth game evicts the first.
        do_clear();
        for (int g = 1; g <= 9; g++) begin
            pulse(g * 10, 100);
            wait_idle("wrap", edges);
            if (g == 8) check("wrap_avg8", 32'(wpm_average), 45);
        end
        check("wrap_count",   32'(count), 8);
        check("wrap_wpm_avg", 32'(wpm_average), 55);
        check("wrap_acc_avg", 32'(acc_average), 100);
        check("wrap_wpm_best", 32'(wpm_best), 90);

        // Overlap: second pulse while busy runs after the first completes.
        do_clear();
        pulse(1023, 1023);
        @(negedge clk);
        @(negedge clk);
        pulse(20, 50);
        wait_idle("ovl1", edges);
        check("ovl1_wpm_avg", 32'(wpm_average), 999);
        check("ovl1_acc_avg", 32'(acc_average), 100);
        check("ovl1_count",   32'(count), 1);
        @(posedge clk);
        #1 check("ovl_restart_busy", 32'(busy), 1);
        wait_idle("ovl2", edges);
        check("ovl2_wpm_avg", 32'(wpm_average), 509);
        check("ovl2_acc_avg", 32'(acc_average), 75);
        check("ovl2_count",   32'(count), 2);

        // Newest pending wins: 10/10 is overwritten by 30/30.
        do_clear();
        pulse(100, 100);
        pulse(10, 10);
        pulse(30, 30);
        wait_idle("nw1", edges);
        @(posedge clk);
        #1;
        wait_idle("nw2", edges);
        check("newest_count",   32'(count), 2);
        check("newest_wpm_avg", 32'(wpm_average), 65);
        check("newest_acc_avg", 32'(acc_average), 65);
        repeat (20) @(posedge clk);
        #1 check("newest_no_third", 32'(count), 2);

        // Clear mid-divide abandons the computation.
        do_clear();
        pulse(70, 70);
        repeat (5) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 check_all_zero("clr_div");
        clear = 1'b0;
        repeat (20) @(posedge clk);
        #1 check_all_zero("clr_div_late");

        // Clear wins over a simultaneous result.
        @(negedge clk);
        wpm_in       = W'(33);
        acc_in       = W'(33);
        clear        = 1'b1;
        result_valid = 1'b1;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        result_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_all_zero("clr_vs_valid");

        // Asynchronous reset in the middle of a computation.
        pulse(80, 80);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 check_all_zero("async_rst_late");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
